mdl_bfu_sched: RTL and testbench

MDL_BFU_SCHED -- requirements
Module: mdl_bfu_sched

---
 rtl/mdl_bfu_sched.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mdl_bfu_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdl_bfu_sched.sv
// ---------------------------------------------------------------------------
// mdl_bfu_sched
//
// Stage/butterfly scheduler for an in-place radix-2 NTT/INTT engine built
// around one pipelined butterfly unit.
//
// Each stage has three phases:
//   - ISSUE: N/2 cycles, one operand pair per cycle.
//   - DRAIN: LAT+1 cycles, so the last write-back of the stage lands before
//     the first read of the next stage.
//   - DONE: a single pulse after the final stage.
// Read addresses travel down a LAT+1 deep delay line, which turns them into
// write-back addresses. The delay line only moves while the butterfly is
// enabled, so it stays aligned with the butterfly pipeline.
//
// Strobe semantics: there is no back-pressure. oRD_EN and oWR_EN are
// single-cycle strobes. Their addresses are valid only in the same cycle and
// are forced to 0 otherwise.
//
// Ports:
//   iSYS_CLK, iSYS_RST          clock, asynchronous active-low reset
//   iSTART                      transform request, sampled in IDLE only
//   iCTL_SEL                    0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande)
//   iCTL_Q                      modulus select, passed through when latched
//   oBUSY, oDONE                status and completion pulse
//   oRD_EN, oRD_ADDR_A/B        operand read strobe and pair addresses
//   oTW_ADDR                    twiddle ROM index
//   oBFU_EN                     butterfly pipeline enable
//   oCTL_SEL, oCTL_Q            mode and modulus latched at start
//   oWR_EN, oWR_ADDR_A/B        write-back strobe and addresses
// ---------------------------------------------------------------------------
module mdl_bfu_sched #(
    parameter int LOGN = 8,
    parameter int D    = 30,
    parameter int LAT  = 8
) (
    input  logic            iSYS_CLK,
    input  logic            iSYS_RST,
    input  logic            iSTART,
    input  logic            iCTL_SEL,
    input  logic [1:0]      iCTL_Q,
    output logic            oBUSY,
    output logic            oDONE,
    output logic            oRD_EN,
    output logic [LOGN-1:0] oRD_ADDR_A,
    output logic [LOGN-1:0] oRD_ADDR_B,
    output logic [LOGN-1:0] oTW_ADDR,
    output logic            oBFU_EN,
    output logic            oCTL_SEL,
    output logic [1:0]      oCTL_Q,
    output logic            oWR_EN,
    output logic [LOGN-1:0] oWR_ADDR_A,
    output logic [LOGN-1:0] oWR_ADDR_B
);

    localparam int N    = 1 << LOGN;
    localparam int HALF = N / 2;
    localparam int SW   = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int DW   = $clog2(LAT + 1);

    // D (coefficient width) is carried for interface compatibility with the
    // butterfly. Scheduling itself does not depend on it.
    generate
        if (LOGN < 2 || LAT < 1 || D < 1) begin : g_bad_params
            $error("mdl_bfu_sched: requires LOGN >= 2, LAT >= 1, D >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [SW-1:0]   r_s;          // stage counter
    logic [LOGN-1:0] r_j;          // butterfly counter within the stage
    logic [DW-1:0]   r_d;          // drain cycle counter
    logic            r_ctl_sel;
    logic [1:0]      r_ctl_q;

    logic            w_j_last;
    logic            w_d_last;
    logic            w_s_last;
    logic            w_rd_en;
    logic            w_bfu_en;
    logic            w_busy;
    logic            w_done;

    logic [SW-1:0]   w_ls;         // log2(len) for the current stage
    logic [SW-1:0]   w_tws;        // log2 of the twiddle base for the stage
    logic [LOGN-1:0] w_mask;
    logic [LOGN-1:0] w_g;
    logic [LOGN-1:0] w_a;
    logic [LOGN-1:0] w_b;
    logic [LOGN-1:0] w_tw;

    // Write-back delay line: one entry per read-to-write cycle.
    logic            r_dl_v [0:LAT];
    logic [LOGN-1:0] r_dl_a [0:LAT];
    logic [LOGN-1:0] r_dl_b [0:LAT];

    assign w_j_last = (r_j == LOGN'(HALF - 1));
    assign w_d_last = (r_d == DW'(LAT));
    assign w_s_last = (r_s == SW'(LOGN - 1));

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and state-decoded strobes
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_bfu_en    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iSTART) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_rd_en  = 1'b1;
                w_bfu_en = 1'b1;
                w_busy   = 1'b1;
                if (w_j_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_bfu_en = 1'b1;
                w_busy   = 1'b1;
                if (w_d_last) begin
                    w_state_nxt = w_s_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Stage / butterfly / drain counters and control latch
    // ---------------------------------------------------------------------
    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            r_s       <= '0;
            r_j       <= '0;
            r_d       <= '0;
            r_ctl_sel <= 1'b0;
            r_ctl_q   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iSTART) begin
                        r_s       <= '0;
                        r_j       <= '0;
                        r_d       <= '0;
                        r_ctl_sel <= iCTL_SEL;
                        r_ctl_q   <= iCTL_Q;
                    end
                end
                S_ISSUE: begin
                    r_d <= '0;
                    if (w_j_last) begin
                        r_j <= '0;
                    end else begin
                        r_j <= r_j + LOGN'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_d_last) begin
                        r_d <= '0;
                        if (!w_s_last) begin
                            r_s <= r_s + SW'(1);
                        end
                    end else begin
                        r_d <= r_d + DW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Butterfly addressing.
    //
    // len is always a power of two:
    //   - NTT:  len = N >> (s+1)
    //   - INTT: len = 1 << s
    // Because of that, g = j/len and o = j%len reduce to a shift and a mask.
    // A = 2*g*len + o is j with the bits at and above log2(len) moved up by
    // one position. B sets the freed bit. The twiddle base is
    // 1 << (LOGN-1-log2(len)) in both modes.
    // ---------------------------------------------------------------------
    always_comb begin
        w_ls   = r_ctl_sel ? r_s : (SW'(LOGN - 1) - r_s);
        w_tws  = r_ctl_sel ? (SW'(LOGN - 1) - r_s) : r_s;
        w_mask = (LOGN'(1) << w_ls) - LOGN'(1);
        w_g    = r_j >> w_ls;
        w_a    = ((r_j & ~w_mask) << 1) | (r_j & w_mask);
        w_b    = w_a | (LOGN'(1) << w_ls);
        w_tw   = (LOGN'(1) << w_tws) + w_g;
    end

    // ---------------------------------------------------------------------
    // Write-back delay line, frozen whenever the butterfly is disabled
    // ---------------------------------------------------------------------
    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            for (int k = 0; k <= LAT; k++) begin
                r_dl_v[k] <= 1'b0;
                r_dl_a[k] <= '0;
                r_dl_b[k] <= '0;
            end
        end else if (w_bfu_en) begin
            r_dl_v[0] <= w_rd_en;
            r_dl_a[0] <= w_rd_en ? w_a : '0;
            r_dl_b[0] <= w_rd_en ? w_b : '0;
            for (int k = 1; k <= LAT; k++) begin
                r_dl_v[k] <= r_dl_v[k-1];
                r_dl_a[k] <= r_dl_a[k-1];
                r_dl_b[k] <= r_dl_b[k-1];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: all derive from reset-cleared registers, so they drop to 0
    // as soon as reset asserts.
    // ---------------------------------------------------------------------
    assign oBUSY      = w_busy;
    assign oDONE      = w_done;
    assign oRD_EN     = w_rd_en;
    assign oRD_ADDR_A = w_rd_en ? w_a  : '0;
    assign oRD_ADDR_B = w_rd_en ? w_b  : '0;
    assign oTW_ADDR   = w_rd_en ? w_tw : '0;
    assign oBFU_EN    = w_bfu_en;
    assign oCTL_SEL   = r_ctl_sel;
    assign oCTL_Q     = r_ctl_q;
    assign oWR_EN     = r_dl_v[LAT];
    assign oWR_ADDR_A = r_dl_v[LAT] ? r_dl_a[LAT] : '0;
    assign oWR_ADDR_B = r_dl_v[LAT] ? r_dl_b[LAT] : '0;

endmodule

// File: tb/tb_mdl_bfu_sched.sv
// ---------------------------------------------------------------------------
// tb_mdl_bfu_sched
//
// Two instances are exercised:
//   - LOGN=3: NTT, INTT, an ignored mid-run start, and a reset abort
//     followed by a restart.
//   - LOGN=8: one full NTT.
// Expected reads, writes and the done cycle come from a reference model.
// The model uses the division/modulo address formulas and absolute cycle
// stamps. Its results are queued when a start is driven and popped when the
// DUT strobes.
// ---------------------------------------------------------------------------
module tb_mdl_bfu_sched;

    localparam int LAT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- LOGN=3 instance ----------------
    logic       rst3, start3, sel3;
    logic [1:0] q3;
    logic       busy3, done3, rd_en3, bfu3, csel3, wr3;
    logic [2:0] rda3, rdb3, tw3, wra3, wrb3;
    logic [1:0] cq3;

    mdl_bfu_sched #(.LOGN(3), .D(30), .LAT(LAT)) u_dut3 (
        .iSYS_CLK  (clk),    .iSYS_RST  (rst3),   .iSTART    (start3),
        .iCTL_SEL  (sel3),   .iCTL_Q    (q3),     .oBUSY     (busy3),
        .oDONE     (done3),  .oRD_EN    (rd_en3), .oRD_ADDR_A(rda3),
        .oRD_ADDR_B(rdb3),   .oTW_ADDR  (tw3),    .oBFU_EN   (bfu3),
        .oCTL_SEL  (csel3),  .oCTL_Q    (cq3),    .oWR_EN    (wr3),
        .oWR_ADDR_A(wra3),   .oWR_ADDR_B(wrb3)
    );

    // ---------------- LOGN=8 instance ----------------
    logic       rst8, start8, sel8;
    logic [1:0] q8;
    logic       busy8, done8, rd_en8, bfu8, csel8, wr8;
    logic [7:0] rda8, rdb8, tw8, wra8, wrb8;
    logic [1:0] cq8;

    mdl_bfu_sched #(.LOGN(8), .D(30), .LAT(LAT)) u_dut8 (
        .iSYS_CLK  (clk),    .iSYS_RST  (rst8),   .iSTART    (start8),
        .iCTL_SEL  (sel8),   .iCTL_Q    (q8),     .oBUSY     (busy8),
        .oDONE     (done8),  .oRD_EN    (rd_en8), .oRD_ADDR_A(rda8),
        .oRD_ADDR_B(rdb8),   .oTW_ADDR  (tw8),    .oBFU_EN   (bfu8),
        .oCTL_SEL  (csel8),  .oCTL_Q    (cq8),    .oWR_EN    (wr8),
        .oWR_ADDR_A(wra8),   .oWR_ADDR_B(wrb8)
    );

    // ---------------- scoreboard state ----------------
    // Entry layout: {cycle[15:0], A[7:0], B[7:0], TW[7:0]} (TW = 0 for writes)
    logic [39:0] rd3_exp_q[$];
    logic [39:0] wr3_exp_q[$];
    int          done3_exp_q[$];
    logic [39:0] rd8_exp_q[$];
    logic [39:0] wr8_exp_q[$];
    int          done8_exp_q[$];

    int          rd3_n = 0, wr3_n = 0, rd8_n = 0, wr8_n = 0;
    int          b3_lo = 1, b3_hi = 0;   // cycle window in which dut3 must be busy
    int          r3_t0 = 0;
    logic        exp_sel3 = 1'b0;
    logic [1:0]  exp_q3 = 2'd0;
    logic        fin8 = 1'b0;

    task automatic push_sched(input int which, input int logn, input bit sel, input int t0);
        int n, per, len, g, o, a, b, tw, w;
        logic [39:0] e_rd, e_wr;
        n   = 1 << logn;
        per = n / 2 + LAT + 1;
        for (int s = 0; s < logn; s++) begin
            for (int j = 0; j < n / 2; j++) begin
                len  = sel ? (1 << s) : (n >> (s + 1));
                g    = j / len;
                o    = j % len;
                a    = (2 * g * len + o) % n;
                b    = (a + len) % n;
                tw   = (sel ? (n >> (s + 1)) + g : (1 << s) + g) % n;
                w    = s * per + j;
                e_rd = {16'(t0 + 1 + w), 8'(a), 8'(b), 8'(tw)};
                e_wr = {16'(t0 + 1 + w + LAT + 1), 8'(a), 8'(b), 8'd0};
                if (which == 3) begin
                    rd3_exp_q.push_back(e_rd);
                    wr3_exp_q.push_back(e_wr);
                end else begin
                    rd8_exp_q.push_back(e_rd);
                    wr8_exp_q.push_back(e_wr);
                end
            end
        end
        if (which == 3) done3_exp_q.push_back(t0 + 1 + logn * per);
        else            done8_exp_q.push_back(t0 + 1 + logn * per);
    endtask

    // ---------------- monitor: LOGN=3 ----------------
    always @(negedge clk) begin : mon3
        logic [39:0] got;
        chk("busy3", 64'(busy3), 64'(cyc >= b3_lo && cyc <= b3_hi));
        chk("bfu_en3", 64'(bfu3), 64'(cyc >= b3_lo && cyc < b3_hi));
        if (cyc >= b3_lo && cyc <= b3_hi) begin
            chk("ctl_sel3", 64'(csel3), 64'(exp_sel3));
            chk("ctl_q3", 64'(cq3), 64'(exp_q3));
        end
        if (rd_en3) begin
            rd3_n++;
            got = {16'(cyc), 8'(rda3), 8'(rdb3), 8'(tw3)};
            if (rd3_exp_q.size() == 0) chk("rd3_unexpected", 64'(got), 64'd0);
            else                       chk("rd3", 64'(got), 64'(rd3_exp_q.pop_front()));
        end else begin
            chk("rd3_idle_addr", 64'({rda3, rdb3, tw3}), 64'd0);
        end
        if (wr3) begin
            wr3_n++;
            got = {16'(cyc), 8'(wra3), 8'(wrb3), 8'd0};
            if (wr3_exp_q.size() == 0) chk("wr3_unexpected", 64'(got), 64'd0);
            else                       chk("wr3", 64'(got), 64'(wr3_exp_q.pop_front()));
        end else begin
            chk("wr3_idle_addr", 64'({wra3, wrb3}), 64'd0);
        end
        if (done3) begin
            if (done3_exp_q.size() == 0) chk("done3_unexpected", 64'(cyc), 64'd0);
            else                         chk("done3_cycle", 64'(cyc), 64'(done3_exp_q.pop_front()));
        end
    end

    // ---------------- monitor: LOGN=8 ----------------
    always @(negedge clk) begin : mon8
        logic [39:0] got;
        if (rd_en8) begin
            rd8_n++;
            got = {16'(cyc), rda8, rdb8, tw8};
            if (rd8_exp_q.size() == 0) chk("rd8_unexpected", 64'(got), 64'd0);
            else                       chk("rd8", 64'(got), 64'(rd8_exp_q.pop_front()));
        end
        if (wr8) begin
            wr8_n++;
            got = {16'(cyc), wra8, wrb8, 8'd0};
            if (wr8_exp_q.size() == 0) chk("wr8_unexpected", 64'(got), 64'd0);
            else                       chk("wr8", 64'(got), 64'(wr8_exp_q.pop_front()));
        end
        if (done8) begin
            if (done8_exp_q.size() == 0) chk("done8_unexpected", 64'(cyc), 64'd0);
            else                         chk("done8_cycle", 64'(cyc), 64'(done8_exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks: LOGN=3 ----------------
    task automatic check_zero3(input string tag);
        chk({tag, "_busy"},  64'(busy3),  64'd0);
        chk({tag, "_done"},  64'(done3),  64'd0);
        chk({tag, "_rd_en"}, 64'(rd_en3), 64'd0);
        chk({tag, "_rd_ad"}, 64'({rda3, rdb3, tw3}), 64'd0);
        chk({tag, "_bfu"},   64'(bfu3),   64'd0);
        chk({tag, "_csel"},  64'(csel3),  64'd0);
        chk({tag, "_cq"},    64'(cq3),    64'd0);
        chk({tag, "_wr_en"}, 64'(wr3),    64'd0);
        chk({tag, "_wr_ad"}, 64'({wra3, wrb3}), 64'd0);
    endtask

    // Drives a start in the current time step (caller aligns to a negedge).
    task automatic begin_run3(input bit sel, input logic [1:0] q);
        sel3     = sel;
        q3       = q;
        start3   = 1'b1;
        r3_t0    = cyc;
        exp_sel3 = sel;
        exp_q3   = q;
        b3_lo    = cyc + 1;
        b3_hi    = cyc + 40;
        rd3_n    = 0;
        wr3_n    = 0;
        push_sched(3, 3, sel, cyc);
    endtask

    task automatic start_run3(input bit sel, input logic [1:0] q);
        @(negedge clk);
        begin_run3(sel, q);
        @(negedge clk);
        start3 = 1'b0;
        sel3   = 1'($urandom_range(0, 1));
        q3     = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_run3(input string tag);
        int k;
        k = 0;
        while ((done3_exp_q.size() != 0 || wr3_exp_q.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_pending"}, 64'(done3_exp_q.size() + wr3_exp_q.size()), 64'd0);
        chk({tag, "_rd_count"}, 64'(rd3_n), 64'd12);
        chk({tag, "_wr_count"}, 64'(wr3_n), 64'd12);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus: LOGN=3 ----------------
    initial begin : drv3
        int k;
        rst3 = 1'b0; start3 = 1'b0; sel3 = 1'b0; q3 = 2'd0;
        repeat (2) @(negedge clk);
        check_zero3("por");
        @(negedge clk);
        rst3 = 1'b1;

        start_run3(1'b0, 2'd2);
        wait_run3("ntt");

        start_run3(1'b1, 2'd1);
        wait_run3("intt");

        // Start pulse with flipped mode while issuing stage 0: must be ignored.
        start_run3(1'b0, 2'd3);
        while (cyc < r3_t0 + 3) @(negedge clk);
        start3 = 1'b1; sel3 = 1'b1; q3 = 2'd0;
        @(negedge clk);
        start3 = 1'b0;
        wait_run3("ignored_start");

        // Reset during stage 1 drain, then an immediate restart.
        start_run3(1'b0, 2'd1);
        while (cyc < r3_t0 + 21) @(negedge clk);
        @(posedge clk);
        #2;
        rst3 = 1'b0;
        rd3_exp_q.delete();
        wr3_exp_q.delete();
        done3_exp_q.delete();
        b3_lo = 1;
        b3_hi = 0;
        #1;
        check_zero3("abort");
        repeat (4) @(negedge clk);
        rst3 = 1'b1;
        begin_run3(1'b1, 2'd2);
        @(negedge clk);
        start3 = 1'b0;
        wait_run3("restart");

        k = 0;
        while (!fin8 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("dut8_finished", 64'(fin8), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus: LOGN=8 ----------------
    initial begin : drv8
        int k;
        rst8 = 1'b0; start8 = 1'b0; sel8 = 1'b0; q8 = 2'd0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        start8 = 1'b1;
        q8     = 2'd3;
        push_sched(8, 8, 1'b0, cyc);
        @(negedge clk);
        start8 = 1'b0;
        q8     = 2'd0;
        repeat (5) @(negedge clk);
        chk("ctl_q8", 64'(cq8), 64'd3);
        chk("busy8", 64'(busy8), 64'd1);
        k = 0;
        while ((done8_exp_q.size() != 0 || wr8_exp_q.size() != 0) && k < 1300) begin
            @(negedge clk);
            k++;
        end
        chk("dut8_pending", 64'(done8_exp_q.size() + wr8_exp_q.size()), 64'd0);
        chk("dut8_rd_count", 64'(rd8_n), 64'd1024);
        chk("dut8_wr_count", 64'(wr8_n), 64'd1024);
        fin8 = 1'b1;
    end

endmodule
